mips_mc_control_hs: RTL
=======================

Name: mips_mc_control_hs

Overview:
Next-generation multicycle MIPS control unit. Adds a variable-latency memory handshake (mem_ready) with a watchdog timeout, bne/addi/j support, and a debug halt/single-step mode. It drives the existing multicycle datapath control signals and exports the current state for board display.

Parameters:
TIMEOUT_W, 8, width of the memory-wait watchdog counter (>=2); TIMEOUT_MAX = 2**TIMEOUT_W-1
STATE_W, 4, width of curr_state

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]
func  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
dbg_halt  in  1  halt at next instruction boundary (level)
dbg_step  in  1  while halted, execute one instruction
pc_en  out  1  PC write enable
i_or_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a  out  1 each  datapath controls
alu_src_b  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_sel  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
curr_state  out  STATE_W  current FSM state
halted  out  1  FSM in HALT
mem_timeout  out  1  FSM in ERROR (sticky)
illegal_op  out  1  one-cycle pulse on unsupported opcode/func

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, HALT=12, ERROR=13.
- Reset (rst=0, async): state FETCH, watchdog counter 0. Outputs are combinational decode of state, so after reset mem_read=1, alu_src_b=01, alu_sel=010; all others 0.
- FETCH: mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD, pc_source=00. ir_write=pc_en=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD. Dispatch: 0x00->R_EXEC, 0x23/0x2B->MEM_ADDR, 0x04/0x05->BRANCH, 0x08->ADDI_EXEC, 0x02->JUMP; other opcodes -> illegal_op=1, instruction boundary (NOP).
- MEM_ADDR, ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD. MEM_ADDR->MEM_RD (lw) / MEM_WR (sw); ADDI_EXEC->ADDI_WB.
- MEM_RD: mem_read, i_or_d=1; on mem_ready->MEM_WB. MEM_WB: reg_write, mem_to_reg=1, reg_dst=0.
- MEM_WR: mem_write, i_or_d=1; on mem_ready->boundary.
- R_EXEC: alu_src_a=1, alu_src_b=00; func 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT -> R_WB. Other func: illegal_op=1, boundary, no reg write. R_WB: reg_write, reg_dst=1, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_en = zero XOR (opcode==0x05).
- JUMP: pc_source=10, pc_en=1. ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0.
- Instruction boundary (exit of MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, ADDI_WB, illegal): next = dbg_halt ? HALT : FETCH.
- HALT: all controls 0, halted=1. If !dbg_halt or dbg_step -> FETCH, else stay. A step runs exactly one instruction, then returns to HALT if dbg_halt is still 1.
- Watchdog: counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle in those states with mem_ready=0. If counter==TIMEOUT_MAX and mem_ready=0 -> ERROR. mem_ready in the same cycle wins. Memory strobes are held stable while waiting.
- ERROR: all controls 0, mem_timeout=1; left only by reset.
- Reset mid-wait aborts the access: strobes drop asynchronously and state returns to FETCH.

Decomposition:
- Shared package mips_pkg: state enum, opcode/func constants, alu_sel encodings, alu_src_b/pc_source encodings.
- One sub-module: mips_alu_decoder (func/op-class -> alu_sel, illegal flag), combinational.

Test Plan:
- lw (0x23) with mem_ready low 3 cycles in FETCH and 2 in MEM_RD -> states 0,0,0,0,1,2,3,3,3,4,0; ir_write/pc_en high only in 4th FETCH cycle; reg_write only in state 4.
- TIMEOUT_W=2, mem_ready held 0 in FETCH -> ERROR after 4 cycles, mem_timeout=1, stays 13 until rst=0.
- bne (0x05) with zero=0 -> pc_en=1 in BRANCH, pc_source=01; zero=1 -> pc_en=0; beq behaves inversely.
- dbg_halt=1 during R-type add -> R_WB then HALT(12), halted=1; 1-cycle dbg_step -> one sw executes (0,1,2,5), then back to HALT.
- opcode 0x3F -> illegal_op pulses one cycle in DECODE, no reg_write/mem_write, next state FETCH; func 0x07 likewise from R_EXEC.
- rst asserted low mid-MEM_WR with mem_ready=0 -> mem_write drops immediately; after release state=0, mem_read=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the handshaked multicycle MIPS control unit:
// FSM states, opcode/func constants and datapath mux/ALU select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12,
    S_ERROR     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_sel_e;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'd0,
    ALUOP_SUB  = 2'd1,
    ALUOP_FUNC = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  // States that hold a memory strobe and wait on mem_ready.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the ALU operation class (add / sub / R-type func) to an alu_sel code;
// flags unsupported func values when decoding R-type instructions.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic [5:0]  func_i,
  output logic [2:0]  alu_sel_o,
  output logic        illegal_o
);

  always_comb begin
    alu_sel_o = ALU_ADD;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: alu_sel_o = ALU_ADD;
      ALUOP_SUB: alu_sel_o = ALU_SUB;
      ALUOP_FUNC: begin
        case (func_i)
          FN_ADD:  alu_sel_o = ALU_ADD;
          FN_SUB:  alu_sel_o = ALU_SUB;
          FN_AND:  alu_sel_o = ALU_AND;
          FN_OR:   alu_sel_o = ALU_OR;
          FN_SLT:  alu_sel_o = ALU_SLT;
          default: illegal_o = 1'b1;
        endcase
      end
      default: alu_sel_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control_hs.sv
// Multicycle MIPS control FSM with mem_ready handshake, memory-wait watchdog
// and debug halt/single-step. Controls are a combinational decode of state.
module mips_mc_control_hs
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned STATE_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               dbg_halt,
  input  logic               dbg_step,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [2:0]         alu_sel,
  output logic [STATE_W-1:0] curr_state,
  output logic               halted,
  output logic               mem_timeout,
  output logic               illegal_op
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] WD_ONE      = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  alu_op_e    alu_op;
  logic [2:0] dec_sel;
  logic       dec_illegal;
  logic       wd_expired;
  state_e     boundary;

  assign alu_op = (state_q == S_R_EXEC) ? ALUOP_FUNC :
                  (state_q == S_BRANCH) ? ALUOP_SUB  : ALUOP_ADD;

  mips_alu_decoder u_alu_dec (
    .alu_op_i  (alu_op),
    .func_i    (func),
    .alu_sel_o (dec_sel),
    .illegal_o (dec_illegal)
  );

  assign wd_expired = (wd_q == TIMEOUT_MAX);
  assign boundary   = dbg_halt ? S_HALT : S_FETCH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_source   = PCSRC_ALU;
    alu_sel     = 3'b000;
    halted      = 1'b0;
    mem_timeout = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_sel   = dec_sel;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready)       state_d = S_DECODE;
        else if (wd_expired) state_d = S_ERROR;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_sel   = dec_sel;
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          OP_J:          state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = boundary;
          end
        endcase
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_sel   = dec_sel;
        if (state_q == S_ADDI_EXEC) state_d = S_ADDI_WB;
        else if (opcode == OP_SW)   state_d = S_MEM_WR;
        else                        state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)       state_d = S_MEM_WB;
        else if (wd_expired) state_d = S_ERROR;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = boundary;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)       state_d = boundary;
        else if (wd_expired) state_d = S_ERROR;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_sel   = dec_sel;
        if (dec_illegal) begin
          illegal_op = 1'b1;
          state_d    = boundary;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = boundary;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_sel   = dec_sel;
        pc_source = PCSRC_ALUOUT;
        // beq takes on zero, bne on !zero
        pc_en     = zero ^ (opcode == OP_BNE);
        state_d   = boundary;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
        state_d   = boundary;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = boundary;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!dbg_halt || dbg_step) state_d = S_FETCH;
      end
      S_ERROR: begin
        mem_timeout = 1'b1;
      end
      default: state_d = S_ERROR;
    endcase
  end

  // Any state change restarts the watchdog, so each memory wait starts at 0.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q)
      wd_d = '0;
    else if (is_wait_state(state_q) && !mem_ready)
      wd_d = wd_q + WD_ONE;
  end

  assign curr_state = STATE_W'(state_q);

endmodule
